// File: rtl/dc_arbiter.sv
// Round-robin arbiter sharing one L1 D$ request port between LSQ (r0) and a secondary client (r1).
// Grant registered one cycle after request; ack/data/fault returned combinationally; a watchdog ends hung cycles.
module dc_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          clk_in,
  input  logic          reset_in,

  input  logic          r0_req,
  input  logic          r0_rd,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wr_data,
  input  logic [2:0]    r0_size,
  input  logic          r0_zero_ext,
  input  logic          r0_inv_flag,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rd_data,
  output logic          r0_fault,

  input  logic          r1_req,
  input  logic          r1_rd,
  input  logic          r1_wr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wr_data,
  input  logic [2:0]    r1_size,
  input  logic          r1_zero_ext,
  input  logic          r1_inv_flag,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rd_data,
  output logic          r1_fault,

  output logic          dc_req,
  output logic          dc_rd,
  output logic          dc_wr,
  output logic [AW-1:0] dc_addr,
  output logic [DW-1:0] dc_wr_data,
  output logic [2:0]    dc_size,
  output logic          dc_zero_ext,
  output logic          dc_inv_flag,
  input  logic          dc_ack,
  input  logic [DW-1:0] dc_rd_data,
  input  logic          dc_fault,

  output logic [1:0]    owner_out,
  output logic          timeout_err
);

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    size;
    logic          zero_ext;
    logic          inv_flag;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner;      // 0 = r0, 1 = r1
  logic        last;       // last requester served
  logic [15:0] wd_cnt;
  req_t        r0_dat, r1_dat, dc_dat;

  logic        grant_vld;
  logic        grant_sel;
  logic        done;
  logic        wd_expire;
  logic [DW-1:0] ret_data;
  logic        ret_fault;

  assign r0_dat = '{rd: r0_rd, wr: r0_wr, addr: r0_addr, wr_data: r0_wr_data,
                    size: r0_size, zero_ext: r0_zero_ext, inv_flag: r0_inv_flag};
  assign r1_dat = '{rd: r1_rd, wr: r1_wr, addr: r1_addr, wr_data: r1_wr_data,
                    size: r1_size, zero_ext: r1_zero_ext, inv_flag: r1_inv_flag};

  assign dc_rd       = dc_dat.rd;
  assign dc_wr       = dc_dat.wr;
  assign dc_addr     = dc_dat.addr;
  assign dc_wr_data  = dc_dat.wr_data;
  assign dc_size     = dc_dat.size;
  assign dc_zero_ext = dc_dat.zero_ext;
  assign dc_inv_flag = dc_dat.inv_flag;

  always_comb begin
    state_nxt   = state;
    grant_vld   = 1'b0;
    grant_sel   = 1'b0;
    done        = 1'b0;
    wd_expire   = 1'b0;
    ret_data    = '0;
    ret_fault   = 1'b0;
    r0_ack      = 1'b0;
    r1_ack      = 1'b0;
    r0_rd_data  = '0;
    r1_rd_data  = '0;
    r0_fault    = 1'b0;
    r1_fault    = 1'b0;
    timeout_err = 1'b0;
    owner_out   = 2'b00;

    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_vld = 1'b1;
          grant_sel = (r0_req && r1_req) ? ~last : r1_req;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        owner_out = owner ? 2'b10 : 2'b01;
        // A real ack always beats the watchdog in the same cycle.
        if (dc_ack) begin
          done      = 1'b1;
          ret_data  = dc_rd_data;
          ret_fault = dc_fault;
          state_nxt = IDLE;
        end else if (wd_cnt == WD_LIMIT) begin
          done      = 1'b1;
          wd_expire = 1'b1;
          ret_fault = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    timeout_err = wd_expire;
    if (done) begin
      if (owner) begin
        r1_ack     = 1'b1;
        r1_rd_data = ret_data;
        r1_fault   = ret_fault;
      end else begin
        r0_ack     = 1'b1;
        r0_rd_data = ret_data;
        r0_fault   = ret_fault;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wd_cnt <= '0;
      dc_req <= 1'b0;
      dc_dat <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        owner  <= grant_sel;
        dc_dat <= grant_sel ? r1_dat : r0_dat;
        dc_req <= 1'b1;
        wd_cnt <= '0;
      end else if (state == BUSY) begin
        if (done) begin
          dc_req <= 1'b0;
          last   <= owner;
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/dc_arbiter.md
# dc_arbiter

Two-requester arbiter sharing the single L1 data-cache request port between the Load/Store queue (requester 0) and a secondary cache client such as the cache-maintenance/debug engine (requester 1). It grants the port round-robin, latches the winner's request fields into registers driving the L1 D$, returns the cache's acknowledge, read data and fault to the owner only, and enforces a no-ack watchdog so that a hung cache cycle cannot deadlock the pipeline.

## Interface
- Parameters:
- AW, 32, address width
- DW, 32, data width (matches RSZ)
- TIMEOUT, 256, BUSY cycles without dc_ack before forced termination; legal range 2..65535
- Ports:
- clk_in  in  1  clock; all logic on the rising edge
- reset_in  in  1  reset; one clock, reset is asynchronous and active-low
- rN_req  in  1  request from requester N (N = 0, 1); held high until rN_ack
- rN_rd, rN_wr  in  1 each  load / store; exactly one is high with rN_req
- rN_addr  in  AW  byte address
- rN_wr_data  in  DW  store data
- rN_size  in  3  bytes: 1, 2 or 4
- rN_zero_ext, rN_inv_flag  in  1 each  LBU/LHU flag; invalidate flag
- rN_ack  out  1  one-cycle completion pulse to requester N
- rN_rd_data  out  DW  load data, valid only with rN_ack
- rN_fault  out  1  fault, valid only with rN_ack
- dc_req  out  1  request to L1 D$ (registered)
- dc_rd, dc_wr, dc_addr, dc_wr_data, dc_size, dc_zero_ext, dc_inv_flag  out  as above  latched request fields (registered)
- dc_ack  in  1  one-cycle completion pulse from L1 D$
- dc_rd_data  in  DW  load data with dc_ack
- dc_fault  in  1  cache/bus fault with dc_ack
- owner_out  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog termination

## Operation
- States: IDLE, BUSY. Registers: state, owner, last (last served requester), wd_cnt (16 bits), all dc_* request fields.
- IDLE: if exactly one rN_req high, grant it. If both high, grant the one that is not last. On grant: latch that requester's fields into dc_*, set dc_req=1, owner_out one-hot, wd_cnt=0, go BUSY.
- BUSY: dc_* held constant from latched registers; requester input changes (including req drop) ignored until completion.
- Completion on dc_ack in BUSY: combinationally rOwner_ack=1, rOwner_rd_data=dc_rd_data, rOwner_fault=dc_fault; non-owner ack=0, rd_data=0, fault=0. Next edge: dc_req=0, owner_out=00, last=owner, state IDLE.
- Watchdog: wd_cnt increments every BUSY cycle without dc_ack. When wd_cnt==TIMEOUT-1 and no dc_ack: rOwner_ack=1, rOwner_fault=1, rOwner_rd_data=0, timeout_err=1 that cycle; return to IDLE as for completion. dc_ack in the same cycle wins (normal completion, no timeout_err).
- dc_ack while IDLE (stray): ignored, no rN_ack.
- Requester protocol: after rN_ack the requester deasserts rN_req next cycle or presents a new request; a req still high in IDLE is a new request.

## Timing
- Reset (reset_in=0, asynchronous): state=IDLE, dc_req=0, all dc_* fields 0, owner_out=00, all rN_ack/rN_fault=0, rN_rd_data=0, timeout_err=0, wd_cnt=0, last=1 (requester 0 wins first contention). Assertion mid-BUSY drops dc_req immediately; no ack delivered.
- Grant latency: rN_req sampled high at edge k → dc_req high after edge k (visible cycle k+1).
- Ack latency: dc_ack → rN_ack same cycle (combinational).
- Minimum spacing: dc_ack cycle, then one IDLE cycle, then next dc_req. Back-to-back throughput: one transaction per (cache latency + 2) cycles.
- Fairness: with both requesting continuously, grants strictly alternate; no requester waits more than one transaction.

## Test plan
- Reset then r0_req only, rd, addr 0x0000_1000, size 4; dc_ack after 3 cycles with dc_rd_data 0xDEAD_BEEF → dc_req cycle 1 with matching fields, r0_ack cycle 4 with r0_rd_data 0xDEAD_BEEF, r1_ack stays 0.
- r0_req and r1_req asserted together from reset, each immediate ack → grant order r0, r1, r0, r1; owner_out 01,10,01,10.
- r1 granted store addr 0x20, wr_data 0x55; r1 changes addr to 0x40 and drops req mid-BUSY → dc_addr stays 0x20 until dc_ack; r1_ack delivered.
- TIMEOUT=4, no dc_ack → r0_ack=1, r0_fault=1, timeout_err=1 on 4th BUSY cycle; dc_req low next cycle; dc_ack on that same 4th cycle instead → normal ack, timeout_err=0.
- dc_ack pulsed while IDLE → no rN_ack; reset_in low mid-BUSY → dc_req, owner_out 0 immediately; after release r0 wins first contention.
